// File: rtl/e_mdu_pkg.sv
// ----------------------------------------------------------------------------
// e_mdu_pkg
// Shared definitions for the E-stage multiply/divide unit. The decoder and the
// hazard unit import the same opcode encoding and cycle defaults.
//   mdu_op_e        : 4-bit MDU opcode encoding
//   mdu_state_e     : MDU control state
//   DEF_MULT_CYCLES : default busy cycles for mult/multu/madd/msub
//   DEF_DIV_CYCLES  : default busy cycles for div/divu
// ----------------------------------------------------------------------------
package e_mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MSUB  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int unsigned DEF_MULT_CYCLES = 5;
   localparam int unsigned DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu_div.sv
// ----------------------------------------------------------------------------
// mdu_div
// Combinational 32-bit divider, signed or unsigned.
//   i_a      : dividend
//   i_b      : divisor (result is don't-care when zero)
//   i_signed : 1 = signed divide, 0 = unsigned
//   o_quot   : quotient, truncated toward zero
//   o_rem    : remainder, sign follows dividend
// ----------------------------------------------------------------------------
module mdu_div (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_signed,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem
);

   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_div_b;
   logic [31:0] w_uq;
   logic [31:0] w_ur;

   // Divide magnitudes, then restore signs. 0x80000000 has no positive
   // 32-bit magnitude but is correct when read as unsigned, so the
   // 0x80000000 / -1 case wraps back to 0x80000000 with remainder 0.
   always_comb begin
      w_neg_a = i_signed & i_a[31];
      w_neg_b = i_signed & i_b[31];
      w_abs_a = w_neg_a ? (~i_a + 32'd1) : i_a;
      w_abs_b = w_neg_b ? (~i_b + 32'd1) : i_b;
      // keep the operator defined for b == 0; the caller discards that result
      w_div_b = (w_abs_b == '0) ? 32'd1 : w_abs_b;
      w_uq    = w_abs_a / w_div_b;
      w_ur    = w_abs_a % w_div_b;
      o_quot  = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
      o_rem   = w_neg_a ? (~w_ur + 32'd1) : w_ur;
   end

endmodule

// File: rtl/e_mdu.sv
// ----------------------------------------------------------------------------
// e_mdu
// E-stage multiply/divide unit with architectural HI/LO registers. The result
// is computed at accept into staging registers; HI/LO take it when busy falls.
// Optional feature macro: MDU_MADD_EN enables MADD/MSUB (signed accumulate
// into {hi,lo}); without it opcodes 7/8 behave as NONE.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   start  : qualifies mdu_op this cycle
//   mdu_op : MDU opcode (e_mdu_pkg::mdu_op_e)
//   rs_val : rs operand
//   rt_val : rt operand
//   flush  : synchronous abort of in-flight operation
//   busy   : operation in progress
//   hi     : HI register
//   lo     : LO register
// ----------------------------------------------------------------------------
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e  r_state;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [63:0] r_stage;
   logic        r_stage_wr;

   mdu_op_e     w_op;
   logic        w_is_mul;
   logic        w_is_div;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [63:0] w_mul_res;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_op = mdu_op_e'(mdu_op);

   mdu_div u_div (
      .i_a      (rs_val),
      .i_b      (rt_val),
      .i_signed (w_op == OP_DIV),
      .o_quot   (w_quot),
      .o_rem    (w_rem)
   );

   // Low 64 bits of a 64x64 product of sign-/zero-extended operands equal
   // the 32x32 signed/unsigned product.
   assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   always_comb begin
      w_is_mul  = 1'b0;
      w_is_div  = 1'b0;
      w_mul_res = '0;
      case (w_op)
         OP_MULT:  begin w_is_mul = 1'b1; w_mul_res = w_prod_s; end
         OP_MULTU: begin w_is_mul = 1'b1; w_mul_res = w_prod_u; end
`ifdef MDU_MADD_EN
         OP_MADD:  begin w_is_mul = 1'b1; w_mul_res = {r_hi, r_lo} + w_prod_s; end
         OP_MSUB:  begin w_is_mul = 1'b1; w_mul_res = {r_hi, r_lo} - w_prod_s; end
`endif
         OP_DIV, OP_DIVU: w_is_div = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_stage    <= '0;
         r_stage_wr <= 1'b0;
      end else if (flush) begin
         // flush wins over a same-cycle start, including MTHI/MTLO
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_stage    <= '0;
         r_stage_wr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (w_is_mul) begin
                     r_stage    <= w_mul_res;
                     r_stage_wr <= 1'b1;
                     r_cnt      <= 4'(MULT_CYCLES);
                     r_busy     <= 1'b1;
                     r_state    <= ST_RUN;
                  end else if (w_is_div) begin
                     // divide by zero still runs full length but writes nothing
                     r_stage    <= {w_rem, w_quot};
                     r_stage_wr <= (rt_val != '0);
                     r_cnt      <= 4'(DIV_CYCLES);
                     r_busy     <= 1'b1;
                     r_state    <= ST_RUN;
                  end else if (w_op == OP_MTHI) begin
                     r_hi <= rs_val;
                  end else if (w_op == OP_MTLO) begin
                     r_lo <= rs_val;
                  end
               end
            end
            ST_RUN: begin
               if (r_cnt == 4'd1) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  if (r_stage_wr) begin
                     r_hi <= r_stage[63:32];
                     r_lo <= r_stage[31:0];
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// ----------------------------------------------------------------------------
// tb_e_mdu
// Self-checking bench for e_mdu. Stimulus pushes the expected HI/LO and busy
// length into a scoreboard; a monitor pops and compares each time busy falls.
// Immediate-effect operations (MTHI/MTLO, NONE, reset) are checked inline.
// Honours MDU_MADD_EN for the MADD/MSUB expectations.
// ----------------------------------------------------------------------------
module tb_e_mdu;
   import e_mdu_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned cyc;   // 0 = busy length not checked
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  mdu_op = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int unsigned errors = 0;
   int unsigned checks = 0;
   exp_t        sb[$];
   logic        prev_busy = 1'b0;
   int unsigned bcnt = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdu_op (mdu_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .flush  (flush),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int unsigned c);
      exp_t e;
      e.hi = h; e.lo = l; e.cyc = c;
      sb.push_back(e);
   endtask

   // monitor: every busy fall presents a result
   always @(negedge clk) begin
      exp_t e;
      if (busy) bcnt++;
      if (prev_busy && !busy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
         end else begin
            e = sb.pop_front();
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            if (e.cyc != 0) chk("sb_busy_cycles", 32'(bcnt), 32'(e.cyc));
         end
         bcnt = 0;
      end
      prev_busy = busy;
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      // scramble operands after accept; result must not follow them
      start = 1'b0; mdu_op = 4'd0; rs_val = 32'hA5A5_5A5A; rt_val = 32'h0000_0003;
   endtask

   task automatic wait_idle(input string name);
      int unsigned n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy=1 after 40 cycles, expected 0", name);
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      reset = 1'b1;

      push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
      issue(4'd1, 32'hFFFF_FFFD, 32'd5);
      chk("mult_hi_during_run", hi, 32'd0);
      wait_idle("mult");

      push(32'h0000_0001, 32'hFFFF_FFFE, 5);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu");

      push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div");

      push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(4'd4, 32'd7, 32'd0);
      wait_idle("divu_zero");

      push(32'h0000_0000, 32'h8000_0000, 10);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf");

      push(32'h0000_0005, 32'h1999_9999, 10);
      issue(4'd4, 32'hFFFF_FFFF, 32'd10);
      wait_idle("divu");

      // flush after 4 busy cycles, with an ignored start while busy
      push(32'h0000_0005, 32'h1999_9999, 4);
      issue(4'd3, 32'd100, 32'd7);
      @(posedge clk); #1;
      start = 1'b1; mdu_op = 4'd1; rs_val = 32'd3; rt_val = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("flush_busy_after", 32'(busy), 32'd0);
      chk("flush_hi", hi, 32'h0000_0005);
      chk("flush_lo", lo, 32'h1999_9999);

      // flush and MTHI in the same cycle: MTHI dropped
      @(posedge clk); #1;
      start = 1'b1; mdu_op = 4'd5; rs_val = 32'hDEAD_BEEF; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_hi", hi, 32'h0000_0005);

      issue(4'd5, 32'h1234_5678, 32'd0);
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_busy", 32'(busy), 32'd0);
      issue(4'd6, 32'h0000_0009, 32'd0);
      chk("mtlo_lo", lo, 32'h0000_0009);
      chk("mtlo_hi_kept", hi, 32'h1234_5678);

      issue(4'd0, 32'h1111_1111, 32'd2);
      issue(4'd12, 32'h2222_2222, 32'd2);
      repeat (3) @(negedge clk);
      chk("none_busy", 32'(busy), 32'd0);
      chk("none_hi", hi, 32'h1234_5678);
      chk("none_lo", lo, 32'h0000_0009);

      issue(4'd5, 32'd0, 32'd0);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
      push(32'h0000_0001, 32'h0000_0000, 5);
      issue(4'd7, 32'd1, 32'd1);
      wait_idle("madd");
      push(32'h0000_0000, 32'hFFFF_FFFA, 5);
      issue(4'd8, 32'd2, 32'd3);
      wait_idle("msub");
`else
      issue(4'd7, 32'd1, 32'd1);
      issue(4'd8, 32'd2, 32'd3);
      repeat (8) @(negedge clk);
      chk("madd_off_busy", 32'(busy), 32'd0);
      chk("madd_off_hi", hi, 32'd0);
      chk("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

      // asynchronous reset mid-DIV
      push(32'd0, 32'd0, 0);
      issue(4'd3, 32'd50, 32'd3);
      @(posedge clk);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("rst_release_busy", 32'(busy), 32'd0);
      chk("rst_release_lo", lo, 32'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
